// File: rtl/spi_ram_master.sv
// SPI master for the SPI-slave/RAM wrapper: serialises 10-bit commands (one bit per clk) into an SS_n frame
// and, for read-data commands, deserialises the returned RAM byte from MISO.
module spi_ram_master #(
    parameter int RD_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        SHIFT,
        GAP,
        RECV,
        DONE
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(RD_GAP - 1);

    state_t     state;
    logic [9:0] word;
    logic [3:0] cnt;
    logic [7:0] shift;
    logic       rd_op;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word      <= '0;
            cnt       <= '0;
            shift     <= '0;
            rd_op     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        word  <= {cmd_op, cmd_data};
                        rd_op <= &cmd_op;
                        state <= CHK;
                        SS_n  <= 1'b0;
                        MOSI  <= cmd_op[1];
                    end
                end
                CHK: begin
                    state <= SHIFT;
                    MOSI  <= word[9];
                    cnt   <= '0;
                end
                SHIFT: begin
                    // word is shifted left each bit so word[8] always holds the next bit to send
                    if (cnt == 4'd9) begin
                        MOSI <= 1'b0;
                        cnt  <= '0;
                        if (rd_op) begin
                            state <= GAP;
                        end else begin
                            state <= DONE;
                            SS_n  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 4'd1;
                        MOSI <= word[8];
                        word <= {word[8:0], 1'b0};
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= RECV;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECV: begin
                    shift <= {shift[6:0], MISO};
                    if (cnt == 4'd7) begin
                        cnt       <= '0;
                        state     <= DONE;
                        SS_n      <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= {shift[6:0], MISO};
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: a behavioural SPI slave/RAM drives MISO, a separate RAM model predicts read data.
module tb_spi_ram_master;
    localparam int G  = 2;
    localparam int G3 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy, ss_n, mosi;
    logic       miso = 1'b0;

    logic       cmd_valid3 = 1'b0;
    logic       cmd_ready3;
    logic [1:0] cmd_op3 = 2'b00;
    logic [7:0] cmd_data3 = 8'h00;
    logic       rsp_valid3;
    logic [7:0] rsp_data3;
    logic       busy3, ss_n3, mosi3;
    logic       miso3 = 1'b0;

    int cyc = 0;
    int nchk = 0;
    int npass = 0;

    spi_ram_master #(.RD_GAP(G)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_ram_master #(.RD_GAP(G3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
        .cmd_data(cmd_data3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
        .SS_n(ss_n3), .MOSI(mosi3), .MISO(miso3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs and the behavioural slave, all evaluated mid-cycle on the falling edge
    int         hs_q[$];
    int         rsp_cyc_q[$];
    logic [7:0] rsp_dat_q[$];
    int         gap_q[$];
    logic [9:0] got_q[$];
    int         hi_run = 0;
    bit         had_frame = 1'b0;
    int         sidx = -1;
    logic [9:0] sword = '0;
    bit         s_rd = 1'b0;
    logic [7:0] s_byte = 8'h00;
    logic [7:0] s_mem [256] = '{default: 8'h00};
    logic [7:0] s_wa = 8'h00;
    logic [7:0] s_ra = 8'h00;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) hs_q.push_back(cyc);
        if (rsp_valid) begin
            rsp_cyc_q.push_back(cyc);
            rsp_dat_q.push_back(rsp_data);
        end
        if (ss_n) begin
            hi_run++;
            sidx = -1;
            s_rd = 1'b0;
            miso = 1'($urandom);
        end else begin
            if (had_frame && hi_run > 0) gap_q.push_back(hi_run);
            hi_run = 0;
            had_frame = 1'b1;
            sidx++;
            if (sidx >= 1 && sidx <= 10) sword = {sword[8:0], mosi};
            if (sidx == 10) begin
                got_q.push_back(sword);
                case (sword[9:8])
                    2'b00:   s_wa = sword[7:0];
                    2'b01:   s_mem[s_wa] = sword[7:0];
                    2'b10:   s_ra = sword[7:0];
                    default: begin s_rd = 1'b1; s_byte = s_mem[s_ra]; end
                endcase
            end
            if (s_rd && sidx >= 11 + G && sidx <= 18 + G) miso = s_byte[7 - (sidx - 11 - G)];
            else miso = 1'($urandom);
        end
    end

    // Reference RAM: what the slave should hold given the commands the bench issued
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] ref_wa = 8'h00;
    logic [7:0] ref_ra = 8'h00;
    logic [7:0] last_rd = 8'h00;

    task automatic ref_apply(input logic [1:0] op, input logic [7:0] d, output logic [7:0] rd);
        rd = 8'h00;
        case (op)
            2'b00:   ref_wa = d;
            2'b01:   ref_mem[ref_wa] = d;
            2'b10:   ref_ra = d;
            default: begin rd = ref_mem[ref_ra]; last_rd = rd; end
        endcase
    endtask

    // Presents a command from just after a rising edge; returns the handshake cycle
    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit keep, output int t, output bit ok);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        ok = 1'b0;
        t = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                t = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        nchk++; if (ss_n !== 1'b1) $display("FAIL reset_ss_n: got %b need 1", ss_n); else npass++;
        nchk++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b need 0", mosi); else npass++;
        nchk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); else npass++;
        nchk++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data: got %h need 00", rsp_data); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else npass++;
        nchk++; if (ss_n3 !== 1'b1) $display("FAIL reset_ss_n3: got %b need 1", ss_n3); else npass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        nchk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b need 1", cmd_ready); else npass++;
        nchk++; if (cmd_ready3 !== 1'b1) $display("FAIL reset_cmd_ready3: got %b need 1", cmd_ready3); else npass++;
    endtask

    task automatic test_write_addr;
        int t;
        bit ok;
        int w0;
        logic [9:0] w;
        logic [7:0] rd;
        logic exp_m, exp_s;
        w = {2'b00, 8'h5A};
        w0 = got_q.size();
        send(2'b00, 8'h5A, 1'b0, t, ok);
        ref_apply(2'b00, 8'h5A, rd);
        nchk++; if (!ok) $display("FAIL wa_handshake: no handshake within budget"); else npass++;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_s = (k == 12);
            exp_m = (k == 1) ? w[9] : (k <= 11) ? w[11 - k] : 1'b0;
            nchk++; if (ss_n !== exp_s) $display("FAIL wa_ss_n T+%0d: got %b need %b", k, ss_n, exp_s); else npass++;
            nchk++; if (mosi !== exp_m) $display("FAIL wa_mosi T+%0d: got %b need %b", k, mosi, exp_m); else npass++;
            nchk++; if (busy !== 1'b1) $display("FAIL wa_busy T+%0d: got %b need 1", k, busy); else npass++;
        end
        @(negedge clk);
        nchk++; if (cmd_ready !== 1'b1) $display("FAIL wa_ready T+13: got %b need 1", cmd_ready); else npass++;
        nchk++;
        if (got_q.size() != w0 + 1 || got_q[w0] !== w)
            $display("FAIL wa_word: got %0d words, first %h, need one word %h", got_q.size() - w0,
                     (got_q.size() > w0) ? got_q[w0] : 10'h0, w);
        else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_readback;
        int t;
        bit ok;
        int r0;
        logic [7:0] rd;
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [7:0] dat [4] = '{8'h10, 8'hC3, 8'h10, 8'h00};
        r0 = rsp_cyc_q.size();
        for (int i = 0; i < 4; i++) begin
            send(ops[i], dat[i], 1'b0, t, ok);
            ref_apply(ops[i], dat[i], rd);
            nchk++; if (!ok) $display("FAIL rb_handshake %0d: no handshake", i); else npass++;
        end
        repeat (30) @(negedge clk);
        nchk++;
        if (rsp_cyc_q.size() != r0 + 1) $display("FAIL rb_pulses: got %0d need 1", rsp_cyc_q.size() - r0);
        else npass++;
        if (rsp_cyc_q.size() > r0) begin
            nchk++;
            if (rsp_cyc_q[r0] != t + 20 + G) $display("FAIL rb_cycle: got T+%0d need T+%0d", rsp_cyc_q[r0] - t, 20 + G);
            else npass++;
            nchk++; if (rsp_dat_q[r0] !== 8'hC3) $display("FAIL rb_data: got %h need c3", rsp_dat_q[r0]); else npass++;
        end
        nchk++; if (rsp_data !== 8'hC3) $display("FAIL rb_hold: got %h need c3", rsp_data); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_deser;
        int t;
        bit ok;
        logic [7:0] rd, addr, val, exp;
        for (int i = 0; i < 3; i++) begin
            addr = (i == 0) ? 8'h33 : 8'($urandom);
            val  = (i == 0) ? 8'hA5 : 8'($urandom);
            send(2'b00, addr, 1'b0, t, ok); ref_apply(2'b00, addr, rd);
            send(2'b01, val, 1'b0, t, ok);  ref_apply(2'b01, val, rd);
            send(2'b10, addr, 1'b0, t, ok); ref_apply(2'b10, addr, rd);
            send(2'b11, 8'($urandom), 1'b0, t, ok);
            ref_apply(2'b11, 8'h00, exp);
            nchk++; if (!ok) $display("FAIL rd_handshake %0d: no handshake", i); else npass++;
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                nchk++;
                if (rsp_valid !== (k == 20 + G)) $display("FAIL rd_valid %0d T+%0d: got %b need %b", i, k, rsp_valid, k == 20 + G);
                else npass++;
                if (k == 20 + G) begin
                    nchk++; if (rsp_data !== exp) $display("FAIL rd_data %0d: got %h need %h", i, rsp_data, exp); else npass++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid;
        int t;
        bit ok;
        int r0, w0;
        nchk++; if (rsp_data !== last_rd) $display("FAIL mid_pre_hold: got %h need %h", rsp_data, last_rd); else npass++;
        w0 = got_q.size();
        send(2'b01, 8'($urandom), 1'b0, t, ok);
        repeat (4) @(negedge clk);
        nchk++; if (ss_n !== 1'b0) $display("FAIL mid_ss_low: got %b need 0", ss_n); else npass++;
        #1 rst = 1'b1;
        #1;
        nchk++; if (ss_n !== 1'b1) $display("FAIL mid_ss_async: got %b need 1", ss_n); else npass++;
        nchk++; if (mosi !== 1'b0) $display("FAIL mid_mosi: got %b need 0", mosi); else npass++;
        nchk++; if (rsp_data !== 8'h00) $display("FAIL mid_rsp_data: got %h need 00", rsp_data); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b need 0", busy); else npass++;
        @(negedge clk);
        rst = 1'b0;
        r0 = rsp_cyc_q.size();
        @(posedge clk);
        #1;
        nchk++; if (cmd_ready !== 1'b1) $display("FAIL mid_ready: got %b need 1", cmd_ready); else npass++;
        repeat (30) @(negedge clk);
        nchk++; if (rsp_cyc_q.size() != r0) $display("FAIL mid_no_rsp: got %0d pulses need 0", rsp_cyc_q.size() - r0); else npass++;
        nchk++; if (got_q.size() != w0) $display("FAIL mid_aborted: got %0d full words need 0", got_q.size() - w0); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int t [4];
        bit ok;
        int h0, w0, r0, g0, nr;
        logic [1:0] op [4];
        logic [7:0] d [4];
        logic [7:0] exp [4];
        int rot;
        rot = $urandom_range(0, 3);
        h0 = hs_q.size(); w0 = got_q.size(); r0 = rsp_cyc_q.size(); g0 = gap_q.size();
        for (int i = 0; i < 4; i++) begin
            op[i] = 2'((i + rot) % 4);
            d[i] = 8'($urandom);
            send(op[i], d[i], (i != 3), t[i], ok);
            ref_apply(op[i], d[i], exp[i]);
            nchk++; if (!ok) $display("FAIL b2b_handshake %0d: no handshake", i); else npass++;
        end
        repeat (30) @(negedge clk);
        nchk++; if (hs_q.size() - h0 != 4) $display("FAIL b2b_hs_count: got %0d need 4", hs_q.size() - h0); else npass++;
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (t[i + 1] - t[i] != ((op[i] == 2'b11) ? 21 + G : 13))
                $display("FAIL b2b_period %0d: got %0d need %0d", i, t[i + 1] - t[i], (op[i] == 2'b11) ? 21 + G : 13);
            else npass++;
        end
        nchk++; if (got_q.size() - w0 != 4) $display("FAIL b2b_words: got %0d need 4", got_q.size() - w0); else npass++;
        for (int i = 0; i < 4 && w0 + i < got_q.size(); i++) begin
            nchk++;
            if (got_q[w0 + i] !== {op[i], d[i]}) $display("FAIL b2b_word %0d: got %h need %h", i, got_q[w0 + i], {op[i], d[i]});
            else npass++;
        end
        nr = 0;
        for (int i = 0; i < 4; i++) begin
            if (op[i] == 2'b11) begin
                nchk++;
                if (rsp_cyc_q.size() <= r0 + nr) $display("FAIL b2b_rsp %0d: got no pulse need one", i);
                else if (rsp_cyc_q[r0 + nr] != t[i] + 20 + G || rsp_dat_q[r0 + nr] !== exp[i])
                    $display("FAIL b2b_rsp %0d: got T+%0d data %h need T+%0d data %h", i, rsp_cyc_q[r0 + nr] - t[i],
                             rsp_dat_q[r0 + nr], 20 + G, exp[i]);
                else npass++;
                nr++;
            end
        end
        nchk++; if (rsp_cyc_q.size() - r0 != nr) $display("FAIL b2b_rsp_count: got %0d need %0d", rsp_cyc_q.size() - r0, nr); else npass++;
        // Between chained frames SS_n stays high for the DONE cycle plus the IDLE handshake cycle
        nchk++; if (gap_q.size() - g0 != 4) $display("FAIL b2b_gap_count: got %0d need 4", gap_q.size() - g0); else npass++;
        for (int i = 1; i < 4 && g0 + i < gap_q.size(); i++) begin
            nchk++; if (gap_q[g0 + i] != 2) $display("FAIL b2b_gap %0d: got %0d need 2", i, gap_q[g0 + i]); else npass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rd_gap3;
        int t;
        bit ok;
        logic [7:0] b;
        b = 8'($urandom);
        cmd_op3 = 2'b11;
        cmd_data3 = 8'($urandom);
        cmd_valid3 = 1'b1;
        ok = 1'b0;
        t = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready3) begin ok = 1'b1; t = cyc; break; end
        end
        @(posedge clk);
        #1;
        cmd_valid3 = 1'b0;
        nchk++; if (!ok) $display("FAIL g3_handshake: no handshake"); else npass++;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k >= 12 + G3 && k <= 19 + G3) miso3 = b[7 - (k - 12 - G3)];
            else if (k == 11 + G3) miso3 = ~b[7];
            else if (k == 20 + G3) miso3 = ~b[0];
            else miso3 = 1'($urandom);
            nchk++;
            if (ss_n3 !== (k > 19 + G3)) $display("FAIL g3_ss_n T+%0d: got %b need %b", k, ss_n3, k > 19 + G3); else npass++;
            nchk++;
            if (rsp_valid3 !== (k == 20 + G3)) $display("FAIL g3_valid T+%0d: got %b need %b", k, rsp_valid3, k == 20 + G3);
            else npass++;
            if (k == 20 + G3) begin
                nchk++; if (rsp_data3 !== b) $display("FAIL g3_data: got %h need %h", rsp_data3, b); else npass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_readback();
        test_read_deser();
        test_reset_mid();
        test_back_to_back();
        test_rd_gap3();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", npass, nchk);
        $fatal(1, "watchdog expired");
    end

endmodule
